dcache_controller: RTL and testbench
====================================

// Module: dcache_controller
// PURPOSE
//   Initiator side of the direct-mapped cache storage array. Accepts CPU
//   load/store requests and does tag compare and hit/miss detection.
//   On a miss it performs the dirty-line writeback and the line refill with
//   data memory, then issues the array write.
//   Sits between the MEM pipeline stage, the cache array and data memory.
// PARAMETERS
//   TAG_W    22   tag width; tag = addr[31:10]
//   INDEX_W  5    index width; index = addr[9:5]; 32 lines
//   LINE_W   256  line width; 8 x 32-bit words; word select = addr[4:2]
// PORTS
//   clock_i        in   1       single clock, rising edge
//   rst_i          in   1       asynchronous, active-high reset
//   p1_addr_i      in   32      CPU byte address (word aligned)
//   p1_data_i      in   32      CPU store data
//   p1_MemRead_i   in   1       load request
//   p1_MemWrite_i  in   1       store request
//   p1_data_o      out  32      load data, valid when request && !p1_stall_o
//   p1_stall_o     out  1       hold the pipeline
//   cache_enable_o out  1       array access enable
//   cache_write_o  out  1       array write strobe, one-cycle pulse
//   cache_index_o  out  5       array index
//   cache_valid_o / cache_dirty_o  out 1 each   line state to write
//   cache_tag_o    out  22      tag to write
//   cache_data_o   out  256     line to write
//   cache_valid_i / cache_dirty_i  in 1 each    line state read
//   cache_tag_i    in   22      tag read
//   cache_data_i   in   256     line read
//   mem_enable_o   out  1       memory request, held until mem_ack_i
//   mem_write_o    out  1       1 = writeback, 0 = refill read
//   mem_addr_o     out  32      line address, low 5 bits 0
//   mem_data_o     out  256     writeback line
//   mem_data_i     in   256     refill line, valid with mem_ack_i
//   mem_ack_i      in   1       one-cycle completion pulse
// BEHAVIOUR
//   - Reset: state=IDLE; line buffer=0; all outputs 0. p1_stall_o is 0
//     while no request is present.
//   - hit = req && cache_valid_i && (cache_tag_i == addr tag); req = Read|Write.
//     cache_enable_o = req; cache_index_o = addr index (combinational).
//   - IDLE, read hit: p1_data_o = selected word; stall 0; zero wait cycles.
//   - IDLE, write hit: same cycle pulse cache_write_o; line = read line with
//     word replaced; valid=1; dirty=1; tag unchanged; stall 0.
//   - Read and write both high: treated as a write.
//   - IDLE, miss: p1_stall_o=1 combinationally. Next state: WB if
//     cache_dirty_i, else REFILL.
//   - WB: mem_enable_o=1; mem_write_o=1; mem_addr_o={cache_tag_i,index,5'b0};
//     mem_data_o=cache_data_i. On mem_ack_i go to REFILL.
//   - REFILL: mem_enable_o=1; mem_write_o=0; mem_addr_o={addr tag,index,5'b0}.
//     On mem_ack_i latch mem_data_i into the line buffer and go to FILL.
//     mem_enable_o is 0 in the cycle after any ack.
//   - FILL: one cycle. Pulse cache_write_o with valid=1, dirty=0, new tag and
//     the buffered line. Go to IDLE, where the request re-evaluates as a hit
//     (a store hit then sets dirty).
//   - p1_stall_o=1 in WB, REFILL and FILL regardless of the request inputs.
//   - CPU holds its request stable while stalled. A request that drops
//     mid-miss does not abort the sequence.
//   - Reset asserted mid-miss returns to IDLE at once. The memory request is
//     abandoned and an outstanding ack is ignored.
//   - Minimum miss latency: clean = 3 cycles + memory latency;
//     dirty = one extra memory round trip.
// STRUCTURE
//   - Shared package/header: FSM state encodings (IDLE, WB, REFILL, FILL),
//     TAG_W/INDEX_W/LINE_W, address field slice constants.
//   - One natural sub-module: dcache_word_merge. Selects or replaces a
//     32-bit word in a 256-bit line by addr[4:2]. Used for the read mux and
//     the store merge.
// TESTING
//   1) Cold read 0x0000_0400, clean miss, memory ack after 10 cycles ->
//      REFILL addr 0x400, FILL writes tag 0x1 with dirty 0, stall drops,
//      word 0 returned.
//   2) Store 0xDEADBEEF to 0x404 after test 1 -> hit with no stall; array
//      write with word 1 replaced and dirty=1.
//   3) Read 0x0000_0804 (same index 0, tag 0x2) after test 2 -> WB to 0x400
//      with the merged line, then REFILL 0x800, FILL, data returned.
//   4) Read and write both high on a hit -> behaves as a write; p1_stall_o 0.
//   5) Assert rst_i in REFILL before ack, ack arrives later -> IDLE, all
//      outputs 0, no array write.
//   6) Write miss on a clean line -> REFILL, FILL with dirty=0, then IDLE hit
//      writes dirty=1; 2 array write pulses total.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared geometry, address-field positions and FSM encoding for the data cache controller.
package dcache_pkg;

  localparam int ADDR_W    = 32;
  localparam int WORD_W    = 32;
  localparam int TAG_W     = 22;
  localparam int INDEX_W   = 5;
  localparam int LINE_W    = 256;
  localparam int WSEL_W    = 3;
  localparam int OFFSET_W  = 5;

  // Address layout: tag = addr[31:10], index = addr[9:5], word select = addr[4:2]
  localparam int TAG_LSB   = 10;
  localparam int INDEX_LSB = 5;
  localparam int WSEL_LSB  = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WB     = 2'd1,
    ST_REFILL = 2'd2,
    ST_FILL   = 2'd3
  } state_t;

  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0]   tag,
                                                  input logic [INDEX_W-1:0] index);
    return {tag, index, {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/dcache_word_merge.sv
// Reads one 32-bit word out of a cache line and builds the same line with that word replaced.
module dcache_word_merge
  import dcache_pkg::*;
(
  input  logic [LINE_W-1:0] i_line,
  input  logic [WSEL_W-1:0] i_wsel,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_rdata,
  output logic [LINE_W-1:0] o_line
);

  // Bit offset of the selected word: word select times 32.
  logic [WSEL_W+4:0] w_off;
  assign w_off = {i_wsel, 5'b00000};

  always_comb begin
    o_rdata = i_line[w_off +: WORD_W];
    o_line  = i_line;
    o_line[w_off +: WORD_W] = i_wdata;
  end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped data cache controller: tag compare, hit service, dirty writeback,
// line refill and the array update that finishes a miss.
module dcache_controller
  import dcache_pkg::*;
(
  input  logic               clock_i,
  input  logic               rst_i,
  input  logic [ADDR_W-1:0]  p1_addr_i,
  input  logic [WORD_W-1:0]  p1_data_i,
  input  logic               p1_MemRead_i,
  input  logic               p1_MemWrite_i,
  output logic [WORD_W-1:0]  p1_data_o,
  output logic               p1_stall_o,
  output logic               cache_enable_o,
  output logic               cache_write_o,
  output logic [INDEX_W-1:0] cache_index_o,
  output logic               cache_valid_o,
  output logic               cache_dirty_o,
  output logic [TAG_W-1:0]   cache_tag_o,
  output logic [LINE_W-1:0]  cache_data_o,
  input  logic               cache_valid_i,
  input  logic               cache_dirty_i,
  input  logic [TAG_W-1:0]   cache_tag_i,
  input  logic [LINE_W-1:0]  cache_data_i,
  output logic               mem_enable_o,
  output logic               mem_write_o,
  output logic [ADDR_W-1:0]  mem_addr_o,
  output logic [LINE_W-1:0]  mem_data_o,
  input  logic [LINE_W-1:0]  mem_data_i,
  input  logic               mem_ack_i,
  output state_t             o_dbg_state
);

  state_t              r_state;
  state_t              w_next;
  logic [TAG_W-1:0]    r_tag;
  logic [INDEX_W-1:0]  r_index;
  logic [LINE_W-1:0]   r_line;
  logic                r_ack_d;

  logic                w_req;
  logic                w_hit;
  logic                w_miss_start;
  logic [TAG_W-1:0]    w_tag;
  logic [INDEX_W-1:0]  w_index;
  logic [WSEL_W-1:0]   w_wsel;
  logic [WORD_W-1:0]   w_rd_word;
  logic [LINE_W-1:0]   w_merged;
  logic                w_mem_en;
  logic                w_mem_ack;
  logic                w_unused_addr_lsb;

  assign w_tag             = p1_addr_i[TAG_LSB +: TAG_W];
  assign w_index           = p1_addr_i[INDEX_LSB +: INDEX_W];
  assign w_wsel            = p1_addr_i[WSEL_LSB +: WSEL_W];
  assign w_unused_addr_lsb = ^p1_addr_i[WSEL_LSB-1:0];

  assign w_req        = p1_MemRead_i | p1_MemWrite_i;
  assign w_hit        = w_req && cache_valid_i && (cache_tag_i == w_tag);
  assign w_miss_start = (r_state == ST_IDLE) && w_req && !w_hit;

  // Memory handshake: mem_enable_o is a level request held until the one-cycle
  // mem_ack_i. An ack only counts while the request is raised, and the request
  // is withdrawn for the cycle after every accepted ack so a back-to-back
  // writeback/refill pair is seen by memory as two distinct requests.
  assign w_mem_en  = !rst_i && !r_ack_d &&
                     ((r_state == ST_WB) || (r_state == ST_REFILL));
  assign w_mem_ack = mem_ack_i && w_mem_en;

  assign o_dbg_state = r_state;

  dcache_word_merge u_word_merge (
    .i_line  (cache_data_i),
    .i_wsel  (w_wsel),
    .i_wdata (p1_data_i),
    .o_rdata (w_rd_word),
    .o_line  (w_merged)
  );

  always_ff @(posedge clock_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_tag   <= '0;
      r_index <= '0;
      r_line  <= '0;
      r_ack_d <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ack_d <= w_mem_ack;
      // The miss address is captured so a request dropped mid-miss still completes.
      if (w_miss_start) begin
        r_tag   <= w_tag;
        r_index <= w_index;
      end
      if ((r_state == ST_REFILL) && w_mem_ack) begin
        r_line <= mem_data_i;
      end
    end
  end

  always_comb begin
    w_next         = r_state;
    p1_data_o      = '0;
    p1_stall_o     = 1'b0;
    cache_enable_o = 1'b0;
    cache_write_o  = 1'b0;
    cache_index_o  = '0;
    cache_valid_o  = 1'b0;
    cache_dirty_o  = 1'b0;
    cache_tag_o    = '0;
    cache_data_o   = '0;
    mem_enable_o   = w_mem_en;
    mem_write_o    = 1'b0;
    mem_addr_o     = '0;
    mem_data_o     = '0;

    if (!rst_i) begin
      case (r_state)
        ST_IDLE: begin
          cache_enable_o = w_req;
          cache_index_o  = w_index;
          if (w_hit) begin
            // A request with both strobes high is serviced as a store.
            if (p1_MemWrite_i) begin
              cache_write_o = 1'b1;
              cache_valid_o = 1'b1;
              cache_dirty_o = 1'b1;
              cache_tag_o   = w_tag;
              cache_data_o  = w_merged;
            end else begin
              p1_data_o = w_rd_word;
            end
          end else if (w_req) begin
            p1_stall_o = 1'b1;
            w_next     = cache_dirty_i ? ST_WB : ST_REFILL;
          end
        end

        ST_WB: begin
          p1_stall_o     = 1'b1;
          cache_enable_o = 1'b1;
          cache_index_o  = r_index;
          mem_write_o    = 1'b1;
          mem_addr_o     = line_addr(cache_tag_i, r_index);
          mem_data_o     = cache_data_i;
          if (w_mem_ack) begin
            w_next = ST_REFILL;
          end
        end

        ST_REFILL: begin
          p1_stall_o    = 1'b1;
          cache_index_o = r_index;
          mem_addr_o    = line_addr(r_tag, r_index);
          if (w_mem_ack) begin
            w_next = ST_FILL;
          end
        end

        ST_FILL: begin
          p1_stall_o     = 1'b1;
          cache_enable_o = 1'b1;
          cache_write_o  = 1'b1;
          cache_index_o  = r_index;
          cache_valid_o  = 1'b1;
          cache_dirty_o  = 1'b0;
          cache_tag_o    = r_tag;
          cache_data_o   = r_line;
          w_next         = ST_IDLE;
        end

        default: w_next = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: behavioural cache array and memory around the DUT,
// a directed vector table, reset/write-miss sequences and a randomized phase.
module tb_dcache_controller;
  import dcache_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUT signals ----------------
  logic [31:0]  p1_addr_i, p1_data_i, p1_data_o;
  logic         p1_MemRead_i, p1_MemWrite_i, p1_stall_o;
  logic         cache_enable_o, cache_write_o, cache_valid_o, cache_dirty_o;
  logic [4:0]   cache_index_o;
  logic [21:0]  cache_tag_o, cache_tag_i;
  logic [255:0] cache_data_o, cache_data_i;
  logic         cache_valid_i, cache_dirty_i;
  logic         mem_enable_o, mem_write_o, mem_ack_i;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o, mem_data_i;
  state_t       dbg_state;

  dcache_controller dut (
    .clock_i        (clk),
    .rst_i          (rst),
    .p1_addr_i      (p1_addr_i),
    .p1_data_i      (p1_data_i),
    .p1_MemRead_i   (p1_MemRead_i),
    .p1_MemWrite_i  (p1_MemWrite_i),
    .p1_data_o      (p1_data_o),
    .p1_stall_o     (p1_stall_o),
    .cache_enable_o (cache_enable_o),
    .cache_write_o  (cache_write_o),
    .cache_index_o  (cache_index_o),
    .cache_valid_o  (cache_valid_o),
    .cache_dirty_o  (cache_dirty_o),
    .cache_tag_o    (cache_tag_o),
    .cache_data_o   (cache_data_o),
    .cache_valid_i  (cache_valid_i),
    .cache_dirty_i  (cache_dirty_i),
    .cache_tag_i    (cache_tag_i),
    .cache_data_i   (cache_data_i),
    .mem_enable_o   (mem_enable_o),
    .mem_write_o    (mem_write_o),
    .mem_addr_o     (mem_addr_o),
    .mem_data_o     (mem_data_o),
    .mem_data_i     (mem_data_i),
    .mem_ack_i      (mem_ack_i),
    .o_dbg_state    (dbg_state)
  );

  logic [609:0] all_out;
  assign all_out = {p1_data_o, p1_stall_o, cache_enable_o, cache_write_o, cache_index_o,
                    cache_valid_o, cache_dirty_o, cache_tag_o, cache_data_o,
                    mem_enable_o, mem_write_o, mem_addr_o, mem_data_o};

  // ---------------- scoreboard bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [255:0] build_line(input logic [31:0] la);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = init_word(la + 32'(k * 4));
    return l;
  endfunction

  // ---------------- cache array model ----------------
  typedef struct packed {
    logic         v;
    logic         d;
    logic [21:0]  tag;
    logic [255:0] data;
  } wr_rec_t;

  logic         arr_v [32] = '{default: 1'b0};
  logic         arr_d [32] = '{default: 1'b0};
  logic [21:0]  arr_t [32] = '{default: '0};
  logic [255:0] arr_l [32] = '{default: '0};
  int           wr_cnt = 0;
  wr_rec_t      last_wr;
  wr_rec_t      wr_log[$];

  assign cache_valid_i = arr_v[cache_index_o];
  assign cache_dirty_i = arr_d[cache_index_o];
  assign cache_tag_i   = arr_t[cache_index_o];
  assign cache_data_i  = arr_l[cache_index_o];

  always @(posedge clk) begin
    if (cache_write_o) begin
      arr_v[cache_index_o] <= cache_valid_o;
      arr_d[cache_index_o] <= cache_dirty_o;
      arr_t[cache_index_o] <= cache_tag_o;
      arr_l[cache_index_o] <= cache_data_o;
      wr_cnt  <= wr_cnt + 1;
      last_wr <= '{cache_valid_o, cache_dirty_o, cache_tag_o, cache_data_o};
      wr_log.push_back('{cache_valid_o, cache_dirty_o, cache_tag_o, cache_data_o});
    end
  end

  // ---------------- memory model / responder ----------------
  logic [255:0] mem_lines [logic [31:0]];
  int           mem_lat = 4;
  int           wb_cnt = 0, rf_cnt = 0;
  logic [31:0]  last_wb_addr, last_rf_addr;
  logic [255:0] last_wb_data;

  initial begin
    logic [31:0]  ra;
    logic         rw;
    logic [255:0] rd;
    int           lat;
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    forever begin
      @(negedge clk);
      if (mem_enable_o === 1'b1) begin
        ra = mem_addr_o; rw = mem_write_o; rd = mem_data_o; lat = mem_lat;
        check("mem_addr_align", 256'(ra[4:0]), 256'd0);
        if (rw) begin
          wb_cnt++; last_wb_addr = ra; last_wb_data = rd;
        end else begin
          rf_cnt++; last_rf_addr = ra;
        end
        repeat (lat - 1) @(negedge clk);
        if (rw) begin
          mem_lines[ra] = rd;
          mem_data_i = '0;
        end else begin
          mem_data_i = mem_lines.exists(ra) ? mem_lines[ra] : build_line(ra);
        end
        mem_ack_i = 1'b1;
        @(negedge clk);
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
      end
    end
  end

  // ---------------- reference model (what the CPU should observe) ----------------
  logic        ref_v [32] = '{default: 1'b0};
  logic        ref_d [32] = '{default: 1'b0};
  logic [21:0] ref_t [32] = '{default: '0};
  logic [31:0] ref_words [logic [31:0]];

  task automatic ref_step(input bit w, input logic [31:0] a, input logic [31:0] d,
                          output bit miss, output bit wb, output logic [31:0] data);
    int          idx;
    logic [21:0] tg;
    idx  = int'(a[9:5]);
    tg   = a[31:10];
    miss = !(ref_v[idx] && ref_t[idx] == tg);
    wb   = miss && ref_d[idx];
    if (miss) begin
      ref_v[idx] = 1'b1; ref_t[idx] = tg; ref_d[idx] = 1'b0;
    end
    if (w) begin
      ref_words[a] = d; ref_d[idx] = 1'b1;
    end
    data = ref_words.exists(a) ? ref_words[a] : init_word(a);
  endtask

  // ---------------- driver ----------------
  task automatic do_access(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] got, output int cyc, output bit timeout);
    @(negedge clk);
    p1_MemRead_i = r; p1_MemWrite_i = w; p1_addr_i = a; p1_data_i = d;
    #1;
    cyc = 0;
    while (p1_stall_o === 1'b1 && cyc < 400) begin
      @(negedge clk); #1;
      cyc++;
    end
    timeout = (cyc >= 400);
    got = p1_data_o;
    @(posedge clk); #1;
    p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    bit          exp_miss;
    int          exp_wb;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [6];

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [31:0]  got, ed;
    int           cyc, wb0, rf0, wr0;
    bit           to, em, ewb;
    logic [255:0] line_a1, line_b3, l;
    logic [31:0]  a, d;
    int           op;

    line_a1 = build_line(32'h400); line_a1[63:32] = 32'hDEADBEEF;
    line_b3 = build_line(32'h800); line_b3[95:64] = 32'hCAFEF00D;

    vecs[0] = '{1'b1, 1'b0, 32'h0000_0400, 32'h0, 10, 1'b1, 0, init_word(32'h400)};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_0404, 32'hDEADBEEF, 3, 1'b0, 0, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0804, 32'h0, 5, 1'b1, 1, init_word(32'h804)};
    vecs[3] = '{1'b1, 1'b1, 32'h0000_0808, 32'hCAFEF00D, 3, 1'b0, 0, 32'h0};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_0808, 32'h0, 3, 1'b0, 0, 32'hCAFEF00D};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_0404, 32'h0, 2, 1'b1, 1, 32'hDEADBEEF};

    rst = 1'b1;
    p1_addr_i = '0; p1_data_i = '0; p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs_zero", 256'($countones(all_out)), 256'd0);
    check("reset_state_idle", 256'(dbg_state), 256'(ST_IDLE));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("idle_no_stall", 256'(p1_stall_o), 256'd0);

    for (int i = 0; i < 6; i++) begin
      mem_lat = vecs[i].lat;
      wb0 = wb_cnt; rf0 = rf_cnt; wr0 = wr_cnt;
      ref_step(vecs[i].wr, vecs[i].addr, vecs[i].wdata, em, ewb, ed);
      do_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, got, cyc, to);
      check($sformatf("vec%0d_timeout", i), 256'(to), 256'd0);
      check($sformatf("vec%0d_miss", i), 256'(cyc != 0), 256'(vecs[i].exp_miss));
      check($sformatf("vec%0d_wb_count", i), 256'(wb_cnt - wb0), 256'(vecs[i].exp_wb));
      check($sformatf("vec%0d_refill_count", i), 256'(rf_cnt - rf0), 256'(vecs[i].exp_miss));
      if (vecs[i].rd && !vecs[i].wr)
        check($sformatf("vec%0d_load_data", i), 256'(got), 256'(vecs[i].exp_data));
      case (i)
        0: begin
          check("t1_refill_addr", 256'(last_rf_addr), 256'h400);
          check("t1_stall_cycles", 256'(cyc), 256'd12);
          check("t1_fill_tag", 256'(last_wr.tag), 256'h1);
          check("t1_fill_dirty", 256'(last_wr.d), 256'd0);
          check("t1_array_writes", 256'(wr_cnt - wr0), 256'd1);
        end
        1: begin
          check("t2_write_dirty", 256'(last_wr.d), 256'd1);
          check("t2_write_tag", 256'(last_wr.tag), 256'h1);
          check("t2_write_line", last_wr.data, line_a1);
        end
        2: begin
          check("t3_wb_addr", 256'(last_wb_addr), 256'h400);
          check("t3_wb_data", last_wb_data, line_a1);
          check("t3_refill_addr", 256'(last_rf_addr), 256'h800);
        end
        3: begin
          check("t4_rw_write_dirty", 256'(last_wr.d), 256'd1);
          check("t4_rw_write_line", last_wr.data, line_b3);
          check("t4_rw_array_writes", 256'(wr_cnt - wr0), 256'd1);
        end
        5: begin
          check("t5b_wb_addr", 256'(last_wb_addr), 256'h800);
          check("t5b_wb_data", last_wb_data, line_b3);
        end
        default: ;
      endcase
    end

    // Reset while the refill is outstanding; the late ack must be ignored.
    mem_lat = 20;
    wr0 = wr_cnt;
    @(negedge clk);
    p1_MemRead_i = 1'b1; p1_addr_i = 32'h0000_1420;
    #1;
    check("rst_mid_miss_stall", 256'(p1_stall_o), 256'd1);
    repeat (4) @(negedge clk);
    #1;
    check("rst_mid_refill_req", 256'(mem_enable_o), 256'd1);
    rst = 1'b1; p1_MemRead_i = 1'b0; p1_addr_i = '0;
    #1;
    check("rst_mid_outputs_zero", 256'($countones(all_out)), 256'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    #1;
    check("rst_after_state_idle", 256'(dbg_state), 256'(ST_IDLE));
    check("rst_after_outputs_zero", 256'($countones(all_out)), 256'd0);
    check("rst_no_array_write", 256'(wr_cnt - wr0), 256'd0);

    // Write miss on a clean line: fill clean, then the re-evaluated hit dirties it.
    mem_lat = 3;
    wb0 = wb_cnt; rf0 = rf_cnt; wr0 = wr_cnt;
    wr_log.delete();
    ref_step(1'b1, 32'h0000_0C48, 32'h1234ABCD, em, ewb, ed);
    do_access(1'b0, 1'b1, 32'h0000_0C48, 32'h1234ABCD, got, cyc, to);
    check("t6_timeout", 256'(to), 256'd0);
    check("t6_array_writes", 256'(wr_cnt - wr0), 256'd2);
    check("t6_wb_count", 256'(wb_cnt - wb0), 256'd0);
    check("t6_refill_count", 256'(rf_cnt - rf0), 256'd1);
    check("t6_refill_addr", 256'(last_rf_addr), 256'h0000_0C40);
    if (wr_log.size() >= 2) begin
      l = build_line(32'h0000_0C40);
      check("t6_fill_dirty", 256'(wr_log[0].d), 256'd0);
      check("t6_fill_tag", 256'(wr_log[0].tag), 256'h3);
      check("t6_fill_line", wr_log[0].data, l);
      l[95:64] = 32'h1234ABCD;
      check("t6_store_dirty", 256'(wr_log[1].d), 256'd1);
      check("t6_store_line", wr_log[1].data, l);
    end

    // Randomized traffic over a few conflicting lines.
    for (int n = 0; n < 150; n++) begin
      a  = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 5) |
           (32'($urandom_range(0, 7)) << 2);
      d  = $urandom;
      op = $urandom_range(0, 2);
      mem_lat = $urandom_range(1, 6);
      wb0 = wb_cnt; rf0 = rf_cnt;
      ref_step(op != 0, a, d, em, ewb, ed);
      if (op == 0) exp_q.push_back(ed);
      do_access(op != 1, op != 0, a, d, got, cyc, to);
      check("rnd_timeout", 256'(to), 256'd0);
      check("rnd_miss", 256'(cyc != 0), 256'(em));
      check("rnd_wb_count", 256'(wb_cnt - wb0), 256'(ewb));
      check("rnd_refill_count", 256'(rf_cnt - rf0), 256'(em));
      if (op == 0 && exp_q.size() > 0) begin
        ed = exp_q.pop_front();
        check("rnd_load_data", 256'(got), 256'(ed));
      end
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
